// File: rtl/decode_control_pipe.sv
// -----------------------------------------------------------------------------
// decode_control_pipe
//
// Decodes the ID-stage opcode into the MIPS control set. The control bits then
// travel through the ID/EX, EX/MEM and MEM/WB control registers.
//
// The block also does the following:
//   - detects load-use hazards and inserts a bubble for each one;
//   - honours a global stall, which freezes every stage;
//   - honours a branch flush, which squashes the ID instruction;
//   - counts bubbles from hazards and flushes in a saturating counter.
//
// Optional feature macro: DECODE_EXT_EN
//   When defined, addi (001000) and j (000010) decode, and ex_jump is a real
//   ID/EX register bit. When undefined, both opcodes are illegal and ex_jump
//   is tied to 0.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   id_valid                ID instruction valid
//   id_opcode               instr[31:26]
//   id_rs, id_rt, id_rd     instr register fields
//   stall                   global freeze; every stage holds
//   flush                   branch taken; the ID instruction becomes a bubble
//   hazard_stall            comb; upstream holds PC and IF/ID while this is 1
//   illegal_op              comb; id_valid with an undecoded opcode
//   ex_ctrl                 ID/EX {RegDst,ALUSrc,ALUOp1,ALUOp0}
//   ex_dest                 ID/EX destination (rd if RegDst, else rt)
//   ex_jump                 ID/EX jump bit
//   mem_ctrl                EX/MEM {Branch,MemRead,MemWrite}
//   wb_ctrl                 MEM/WB {RegWrite,MemtoReg}
//   bubble_cnt              saturating count of hazard/flush bubbles
//
// Handshake: there is no ready/valid pair. id_valid qualifies the ID fields.
// While hazard_stall is 1, the ID instruction is not accepted and must be
// presented again. While stall is 1, nothing moves.
// -----------------------------------------------------------------------------
module decode_control_pipe #(
    parameter int REG_AW    = 5,
    parameter int ZERO_SKIP = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              stall,
    input  logic              flush,
    output logic              hazard_stall,
    output logic              illegal_op,
    output logic [3:0]        ex_ctrl,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_jump,
    output logic [2:0]        mem_ctrl,
    output logic [1:0]        wb_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
`ifdef DECODE_EXT_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`endif

    // Decoded control for the ID instruction.
    logic        w_regdst, w_alusrc, w_memtoreg, w_regwrite;
    logic        w_memread, w_memwrite, w_branch, w_aluop1, w_aluop0;
    logic        w_known;
`ifdef DECODE_EXT_EN
    logic        w_jump;
`endif

    // ID/EX registers
    logic [3:0]        r_idex_ex;
    logic [2:0]        r_idex_m;
    logic [1:0]        r_idex_wb;
    logic [REG_AW-1:0] r_idex_dest;
    logic [REG_AW-1:0] r_idex_rt;
`ifdef DECODE_EXT_EN
    logic              r_idex_jump;
`endif
    // EX/MEM registers
    logic [2:0]        r_exmem_m;
    logic [1:0]        r_exmem_wb;
    // MEM/WB register
    logic [1:0]        r_memwb_wb;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_bubble;
    logic              w_count;
    logic              w_rt_hit;
    logic              w_zero_skip;

    always_comb begin
        w_regdst   = 1'b0;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_branch   = 1'b0;
        w_aluop1   = 1'b0;
        w_aluop0   = 1'b0;
        w_known    = 1'b1;
`ifdef DECODE_EXT_EN
        w_jump     = 1'b0;
`endif
        case (id_opcode)
            OP_R: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_aluop1   = 1'b1;
            end
            OP_LW: begin
                w_alusrc   = 1'b1;
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
            end
            OP_SW: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            OP_BEQ: begin
                w_branch   = 1'b1;
                w_aluop0   = 1'b1;
            end
`ifdef DECODE_EXT_EN
            OP_ADDI: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_J: begin
                w_jump     = 1'b1;
            end
`endif
            default: w_known = 1'b0;
        endcase
    end

    assign illegal_op = id_valid & ~w_known;

    // A load into register 0 never produces a value that anyone can use.
    // When ZERO_SKIP is set, such a load is not treated as a hazard.
    assign w_rt_hit     = (r_idex_rt == id_rs) | (r_idex_rt == id_rt);
    assign w_zero_skip  = (ZERO_SKIP != 0) && (r_idex_rt == '0);
    assign hazard_stall = id_valid & r_idex_m[1] & w_rt_hit & ~w_zero_skip;

    // A bubble enters ID/EX on flush, on a hazard, or when ID is empty.
    // Only flush and hazard bubbles are counted. When both happen together,
    // they count as one bubble.
    assign w_count  = flush | hazard_stall;
    assign w_bubble = w_count | ~id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex_ex    <= '0;
            r_idex_m     <= '0;
            r_idex_wb    <= '0;
            r_idex_dest  <= '0;
            r_idex_rt    <= '0;
            r_exmem_m    <= '0;
            r_exmem_wb   <= '0;
            r_memwb_wb   <= '0;
            r_bubble_cnt <= '0;
        end else if (!stall) begin
            if (w_bubble) begin
                r_idex_ex   <= '0;
                r_idex_m    <= '0;
                r_idex_wb   <= '0;
                r_idex_dest <= '0;
                r_idex_rt   <= '0;
            end else begin
                r_idex_ex   <= {w_regdst, w_alusrc, w_aluop1, w_aluop0};
                r_idex_m    <= {w_branch, w_memread, w_memwrite};
                r_idex_wb   <= {w_regwrite, w_memtoreg};
                r_idex_dest <= w_regdst ? id_rd : id_rt;
                r_idex_rt   <= id_rt;
            end
            if (w_count && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
            r_exmem_m  <= r_idex_m;
            r_exmem_wb <= r_idex_wb;
            r_memwb_wb <= r_exmem_wb;
        end
    end

`ifdef DECODE_EXT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex_jump <= 1'b0;
        end else if (!stall) begin
            r_idex_jump <= w_bubble ? 1'b0 : w_jump;
        end
    end
    assign ex_jump = r_idex_jump;
`else
    assign ex_jump = 1'b0;
`endif

    assign ex_ctrl    = r_idex_ex;
    assign ex_dest    = r_idex_dest;
    assign mem_ctrl   = r_exmem_m;
    assign wb_ctrl    = r_memwb_wb;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_decode_control_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_control_pipe
//
// Directed testbench for decode_control_pipe. Every expected value is worked
// out by hand from the decode table and the pipeline timing.
//
// The DUT uses CNT_W=3, so bubble counter saturation is reached after only
// seven bubbles.
// -----------------------------------------------------------------------------
module tb_decode_control_pipe;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [5:0]        id_opcode;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              stall, flush;
    logic              hazard_stall, illegal_op, ex_jump;
    logic [3:0]        ex_ctrl;
    logic [REG_AW-1:0] ex_dest;
    logic [2:0]        mem_ctrl;
    logic [1:0]        wb_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks   = 0;
    int failures = 0;

    decode_control_pipe #(.REG_AW(REG_AW), .ZERO_SKIP(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .stall(stall), .flush(flush),
        .hazard_stall(hazard_stall), .illegal_op(illegal_op), .ex_ctrl(ex_ctrl),
        .ex_dest(ex_dest), .ex_jump(ex_jump), .mem_ctrl(mem_ctrl),
        .wb_ctrl(wb_ctrl), .bubble_cnt(bubble_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
    endtask

    // Used by the bubble counter saturation loop.
    task automatic hazard_pair();
        set_id(1'b1, 6'b100011, 5'd1, 5'd9, 5'd0);
        tick();
        set_id(1'b1, 6'b000000, 5'd9, 5'd2, 5'd3);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("rst_ex_ctrl", ex_ctrl, 0);
        check("rst_mem_ctrl", mem_ctrl, 0);
        check("rst_wb_ctrl", wb_ctrl, 0);
        check("rst_bubble", bubble_cnt, 0);
        check("rst_hazard", hazard_stall, 0);
        check("rst_illegal", illegal_op, 0);
        #12 rst_n = 1'b1;
        tick();

        // R-type instruction with rd=3
        set_id(1'b1, 6'b000000, 5'd1, 5'd2, 5'd3);
        #0;
        check("r_illegal", illegal_op, 0);
        tick();
        check("r_ex_ctrl", ex_ctrl, 4'b1010);
        check("r_ex_dest", ex_dest, 3);
        set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        check("r_mem_ctrl", mem_ctrl, 3'b000);
        check("idle_ex_ctrl", ex_ctrl, 0);
        tick();
        check("r_wb_ctrl", wb_ctrl, 2'b10);
        check("idle_no_count", bubble_cnt, 0);

        // lw rt=5, followed by an add with rs=5
        set_id(1'b1, 6'b100011, 5'd1, 5'd5, 5'd0);
        tick();
        check("lw_ex_ctrl", ex_ctrl, 4'b0100);
        check("lw_ex_dest", ex_dest, 5);
        set_id(1'b1, 6'b000000, 5'd5, 5'd6, 5'd7);
        #0;
        check("lu_hazard", hazard_stall, 1);
        tick();
        check("lu_bubble_ex", ex_ctrl, 0);
        check("lu_bubble_dest", ex_dest, 0);
        check("lu_bubble_cnt", bubble_cnt, 1);
        check("lu_mem_ctrl", mem_ctrl, 3'b010);
        check("lu_hazard_clr", hazard_stall, 0);
        tick();
        check("add_ex_ctrl", ex_ctrl, 4'b1010);
        check("add_ex_dest", ex_dest, 7);
        check("lw_wb_ctrl", wb_ctrl, 2'b11);

        // lw rt=0 followed by rs=0: ZERO_SKIP means no hazard
        set_id(1'b1, 6'b100011, 5'd1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 6'b000000, 5'd0, 5'd0, 5'd4);
        #0;
        check("zs_hazard", hazard_stall, 0);
        tick();
        check("zs_ex_ctrl", ex_ctrl, 4'b1010);
        check("zs_ex_dest", ex_dest, 4);
        check("zs_bubble", bubble_cnt, 1);

        // beq with flush
        set_id(1'b1, 6'b000100, 5'd1, 5'd2, 5'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_ex_ctrl", ex_ctrl, 0);
        check("fl_bubble", bubble_cnt, 2);
        tick();
        check("beq_ex_ctrl", ex_ctrl, 4'b0001);
        set_id(1'b1, 6'b100011, 5'd1, 5'd9, 5'd0);
        tick();

        // Pipeline now holds ID/EX=lw, EX/MEM=beq.
        // Stall for 3 cycles while a hazard is pending.
        set_id(1'b1, 6'b000000, 5'd9, 5'd2, 5'd3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("st_ex_ctrl", ex_ctrl, 4'b0100);
        check("st_ex_dest", ex_dest, 9);
        check("st_mem_ctrl", mem_ctrl, 3'b100);
        check("st_wb_ctrl", wb_ctrl, 2'b00);
        check("st_bubble", bubble_cnt, 2);
        stall = 1'b0;
        tick();
        check("st_rel_bubble", bubble_cnt, 3);
        check("st_rel_ex", ex_ctrl, 0);
        check("st_rel_mem", mem_ctrl, 3'b010);

        // Flush and hazard in the same cycle count as one bubble
        set_id(1'b1, 6'b100011, 5'd1, 5'd9, 5'd0);
        tick();
        set_id(1'b1, 6'b000000, 5'd9, 5'd2, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fh_one_bubble", bubble_cnt, 4);

        // Bubble counter saturation
        for (int i = 0; i < 3; i++) hazard_pair();
        check("sat_reach", bubble_cnt, 7);
        hazard_pair();
        check("sat_hold", bubble_cnt, 7);

        // addi opcode
        set_id(1'b1, 6'b001000, 5'd1, 5'd2, 5'd3);
        #0;
`ifdef DECODE_EXT_EN
        check("addi_illegal", illegal_op, 0);
        tick();
        check("addi_ex_ctrl", ex_ctrl, 4'b0100);
        set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        check("addi_wb_ctrl", wb_ctrl, 2'b10);
`else
        check("addi_illegal", illegal_op, 1);
        tick();
        check("addi_ex_ctrl", ex_ctrl, 0);
`endif

        // j opcode
        set_id(1'b1, 6'b000010, 5'd0, 5'd0, 5'd0);
        #0;
`ifdef DECODE_EXT_EN
        check("j_illegal", illegal_op, 0);
        tick();
        check("j_jump", ex_jump, 1);
`else
        check("j_illegal", illegal_op, 1);
        tick();
        check("j_jump", ex_jump, 0);
`endif
        check("j_ex_ctrl", ex_ctrl, 0);

        // illegal_op requires id_valid
        set_id(1'b0, 6'b111111, 5'd0, 5'd0, 5'd0);
        #0;
        check("inv_illegal", illegal_op, 0);

        // Reset mid-stream drops everything immediately
        set_id(1'b1, 6'b100011, 5'd1, 5'd9, 5'd0);
        tick();
        check("pre_rst_ex", ex_ctrl, 4'b0100);
        set_id(1'b1, 6'b000000, 5'd9, 5'd2, 5'd3);
        #1 rst_n = 1'b0;
        #1;
        check("mr_ex_ctrl", ex_ctrl, 0);
        check("mr_ex_dest", ex_dest, 0);
        check("mr_mem_ctrl", mem_ctrl, 0);
        check("mr_wb_ctrl", wb_ctrl, 0);
        check("mr_bubble", bubble_cnt, 0);
        check("mr_hazard", hazard_stall, 0);
        check("mr_jump", ex_jump, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
